atm_txn_controller: RTL and testbench
=====================================

Name: atm_txn_controller

Overview:
Sequences all account-balance transactions (view, deposit, withdraw) against the shared account balance RAM of the ATM. Accepts one request at a time over a valid/ready handshake, performs read-check-writeback on the RAM, and returns a status plus the resulting balance over a second valid/ready handshake. It is the only RAM master, so balance updates are never interleaved.

Parameters:
NUM_ACCOUNTS, 10, number of valid account IDs (0..NUM_ACCOUNTS-1)
ID_W, 4, account ID width
BAL_W, 5, balance/amount width (unsigned)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_id  input  ID_W  target account
req_op  input  2  00 view, 01 deposit, 10 withdraw, 11 reserved
req_amount  input  BAL_W  deposit/withdraw amount (ignored for view)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_status  output  2  00 OK, 01 bad ID, 10 insufficient funds, 11 overflow/bad op
rsp_balance  output  BAL_W  resulting balance
mem_addr  output  ID_W  RAM address
mem_we  output  1  RAM write enable (one cycle)
mem_wdata  output  BAL_W  RAM write data
mem_rdata  input  BAL_W  RAM read data, synchronous, valid one cycle after mem_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1 once released, rsp_valid=0, rsp_status=00, rsp_balance=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, READ, CHECK, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register id/op/amount. If id>=NUM_ACCOUNTS -> RESP with status 01, balance 0, no RAM access. If op=11 -> RESP with status 11, balance 0, no RAM access. Otherwise -> READ.
- READ: mem_addr=registered id; -> CHECK.
- CHECK: sample mem_rdata as old balance.
  - view: status 00, balance=old -> RESP (no write).
  - deposit: compute in BAL_W+1 bits; if old+amount > 2^BAL_W-1, status 11, balance=old -> RESP; else new=old+amount -> WRITE.
  - withdraw: if amount>old, status 10, balance=old -> RESP; else new=old-amount -> WRITE. Withdraw of 0 and exact-balance withdraw are legal (OK).
- WRITE: mem_we=1 for exactly one cycle, mem_addr=id, mem_wdata=new; status 00, balance=new -> RESP.
- RESP: rsp_valid=1, rsp_status/rsp_balance stable until rsp_valid&&rsp_ready; then -> IDLE. req_ready=0 in every state but IDLE.
- Latency (accept to rsp_valid): 3 cycles for view, error-in-CHECK, or bad-ID/bad-op (1 cycle for the latter); 4 cycles for successful deposit/withdraw.
- rsp_ready held high: next request acceptable the cycle after handshake (no back-to-back in same cycle).
- Reset mid-operation: transaction discarded; if asserted during WRITE, mem_we drops immediately and the write is not guaranteed.
- mem_we never asserted outside WRITE; at most one write per transaction.

Optional Feature:
ATM_TXN_COUNT_EN: adds output txn_count [7:0], counting transactions completed with status 00 (incremented on RESP handshake), saturating at 255, reset to 0. Without the macro the port and counter do not exist; all other behaviour identical.

Test Plan:
- RAM[3]=7; view id 3 -> rsp status 00, balance 7, mem_we never high, rsp_valid 3 cycles after accept.
- RAM[2]=10; withdraw 4 from id 2 -> status 00, balance 6, one mem_we pulse addr 2 data 6; then withdraw 7 -> status 10, balance 6, no write.
- RAM[5]=30; deposit 2 -> status 11, balance 30, no write; deposit 1 -> status 00, balance 31, write 31.
- Request id 12 (>=10) or op 11 -> status 01 / 11, balance 0, no RAM read or write, rsp_valid 1 cycle after accept.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/status/balance stable, req_ready=0, second req_valid ignored until handshake completes.
- Assert rst_n=0 during WRITE -> mem_we, rsp_valid drop asynchronously; after release req_ready=1, outputs at reset values; with ATM_TXN_COUNT_EN, txn_count=0.

Source files
------------

// File: rtl/atm_txn_controller_if.sv
// Request, response and balance-RAM signal bundle for atm_txn_controller.
// slave: the controller side; master: the requester, response consumer and RAM.
interface atm_txn_controller_if #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned BAL_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [ID_W-1:0]  req_id;
  logic [1:0]       req_op;
  logic [BAL_W-1:0] req_amount;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [BAL_W-1:0] rsp_balance;

  logic [ID_W-1:0]  mem_addr;
  logic             mem_we;
  logic [BAL_W-1:0] mem_wdata;
  logic [BAL_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_id, req_op, req_amount, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_status, rsp_balance, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_id, req_op, req_amount, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_status, rsp_balance, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/atm_txn_controller.sv
// Read-check-writeback sequencer for ATM account balances; the single balance-RAM master.
// Optional ATM_TXN_COUNT_EN adds txn_count, a saturating count of OK transactions.
module atm_txn_controller #(
  parameter int unsigned NUM_ACCOUNTS = 10,
  parameter int unsigned ID_W         = 4,
  parameter int unsigned BAL_W        = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  atm_txn_controller_if.slave bus
`ifdef ATM_TXN_COUNT_EN
  ,
  output logic [7:0]          txn_count
`endif
);

  localparam logic [1:0] OpView     = 2'b00;
  localparam logic [1:0] OpDeposit  = 2'b01;
  localparam logic [1:0] OpWithdraw = 2'b10;
  localparam logic [1:0] OpRsvd     = 2'b11;

  localparam logic [1:0] StatusOk       = 2'b00;
  localparam logic [1:0] StatusBadId    = 2'b01;
  localparam logic [1:0] StatusNoFunds  = 2'b10;
  localparam logic [1:0] StatusOverflow = 2'b11;

  typedef enum logic [2:0] {StIdle, StRead, StCheck, StWrite, StResp} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [BAL_W-1:0] amt_q, amt_d;
  logic [1:0]       status_q, status_d;
  // Holds the new balance from CHECK through WRITE, then the reported balance in RESP.
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [BAL_W:0]   sum;

  logic             req_ready;
  logic             rsp_valid;
  logic [ID_W-1:0]  mem_addr;
  logic             mem_we;
  logic [BAL_W-1:0] mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      id_q     <= '0;
      op_q     <= '0;
      amt_q    <= '0;
      status_q <= StatusOk;
      bal_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      op_q     <= op_d;
      amt_q    <= amt_d;
      status_q <= status_d;
      bal_q    <= bal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    op_d      = op_q;
    amt_d     = amt_q;
    status_d  = status_q;
    bal_d     = bal_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    sum       = {1'b0, bus.mem_rdata} + {1'b0, amt_q};

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          id_d  = bus.req_id;
          op_d  = bus.req_op;
          amt_d = bus.req_amount;
          if (32'(bus.req_id) >= NUM_ACCOUNTS) begin
            status_d = StatusBadId;
            bal_d    = '0;
            state_d  = StResp;
          end else if (bus.req_op == OpRsvd) begin
            status_d = StatusOverflow;
            bal_d    = '0;
            state_d  = StResp;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        mem_addr = id_q;
        state_d  = StCheck;
      end
      StCheck: begin
        unique case (op_q)
          OpView: begin
            status_d = StatusOk;
            bal_d    = bus.mem_rdata;
            state_d  = StResp;
          end
          OpDeposit: begin
            if (sum[BAL_W]) begin
              status_d = StatusOverflow;
              bal_d    = bus.mem_rdata;
              state_d  = StResp;
            end else begin
              bal_d   = sum[BAL_W-1:0];
              state_d = StWrite;
            end
          end
          OpWithdraw: begin
            if (amt_q > bus.mem_rdata) begin
              status_d = StatusNoFunds;
              bal_d    = bus.mem_rdata;
              state_d  = StResp;
            end else begin
              bal_d   = bus.mem_rdata - amt_q;
              state_d = StWrite;
            end
          end
          default: begin
            // Reserved ops are rejected in IDLE; kept only as a safe fallback.
            status_d = StatusOverflow;
            bal_d    = '0;
            state_d  = StResp;
          end
        endcase
      end
      StWrite: begin
        mem_we    = 1'b1;
        mem_addr  = id_q;
        mem_wdata = bal_q;
        status_d  = StatusOk;
        state_d   = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_status  = status_q;
  assign bus.rsp_balance = bal_q;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_we      = mem_we;
  assign bus.mem_wdata   = mem_wdata;

`ifdef ATM_TXN_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (rsp_valid && bus.rsp_ready && status_q == StatusOk && count_q != 8'hFF) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign txn_count = count_q;
`endif

endmodule

// File: tb/tb_atm_txn_controller.sv
// Self-checking bench for atm_txn_controller: vector table, response scoreboard,
// back-pressure and reset-during-write sequences; define ATM_TXN_COUNT_EN to cover txn_count.
module tb_atm_txn_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  atm_txn_controller_if #(.ID_W(4), .BAL_W(5)) bus ();

`ifdef ATM_TXN_COUNT_EN
  logic [7:0] txn_count;
`endif

  atm_txn_controller #(
    .NUM_ACCOUNTS(10),
    .ID_W        (4),
    .BAL_W       (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef ATM_TXN_COUNT_EN
    ,
    .txn_count(txn_count)
`endif
  );

  always #5 clk = ~clk;

  // Balance RAM with synchronous read; write count and last write are recorded.
  logic [4:0] ram [16] = '{2: 5'd10, 3: 5'd7, 5: 5'd30, default: 5'd0};
  int unsigned wr_cnt = 0;
  logic [3:0]  last_waddr = '0;
  logic [4:0]  last_wdata = '0;

  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt            <= wr_cnt + 1;
      last_waddr        <= bus.mem_addr;
      last_wdata        <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic [3:0] id;
    logic [1:0] op;
    logic [4:0] amt;
    logic [1:0] exp_st;
    logic [4:0] exp_bal;
    int         exp_wr;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [4:0] bal;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int ok_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [4:0] bal);
    exp_t e;
    e.st  = st;
    e.bal = bal;
    sb.push_back(e);
  endtask

  // Called at a negedge where rsp_valid is high.
  task automatic check_resp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, " scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({name, " rsp_status"}, int'(bus.rsp_status), int'(e.st));
      chk({name, " rsp_balance"}, int'(bus.rsp_balance), int'(e.bal));
      if (e.st == 2'b00) ok_cnt++;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned wr0;
    int lat;
    int guard;
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_id     = v.id;
    bus.req_op     = v.op;
    bus.req_amount = v.amt;
    wr0 = wr_cnt;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, " req_ready"}, int'(bus.req_ready), 1);
    push_exp(v.exp_st, v.exp_bal);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(lat);
    chk({nm, " latency"}, lat, v.exp_lat);
    check_resp(nm);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " writes"}, int'(wr_cnt - wr0), v.exp_wr);
    if (v.exp_wr != 0) begin
      chk({nm, " waddr"}, int'(last_waddr), int'(v.id));
      chk({nm, " wdata"}, int'(last_wdata), int'(v.exp_bal));
      chk({nm, " ram"}, int'(ram[v.id]), int'(v.exp_bal));
    end
  endtask

  vec_t vecs[13];

  initial begin
    int lat;
    int guard;
    int unsigned wr0;

    // id, op, amount, status, balance, writes, latency
    vecs[0]  = '{4'd3,  2'b00, 5'd0,  2'b00, 5'd7,  0, 3};
    vecs[1]  = '{4'd2,  2'b10, 5'd4,  2'b00, 5'd6,  1, 4};
    vecs[2]  = '{4'd2,  2'b10, 5'd7,  2'b10, 5'd6,  0, 3};
    vecs[3]  = '{4'd5,  2'b01, 5'd2,  2'b11, 5'd30, 0, 3};
    vecs[4]  = '{4'd5,  2'b01, 5'd1,  2'b00, 5'd31, 1, 4};
    vecs[5]  = '{4'd12, 2'b00, 5'd0,  2'b01, 5'd0,  0, 1};
    vecs[6]  = '{4'd3,  2'b11, 5'd1,  2'b11, 5'd0,  0, 1};
    vecs[7]  = '{4'd2,  2'b10, 5'd6,  2'b00, 5'd0,  1, 4};
    vecs[8]  = '{4'd2,  2'b10, 5'd0,  2'b00, 5'd0,  1, 4};
    vecs[9]  = '{4'd0,  2'b01, 5'd31, 2'b00, 5'd31, 1, 4};
    vecs[10] = '{4'd5,  2'b00, 5'd0,  2'b00, 5'd31, 0, 3};
    vecs[11] = '{4'd10, 2'b01, 5'd1,  2'b01, 5'd0,  0, 1};
    vecs[12] = '{4'd9,  2'b00, 5'd0,  2'b00, 5'd0,  0, 3};

    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.req_op     = '0;
    bus.req_amount = '0;
    bus.rsp_ready  = 1'b1;

    // Reset values while held in reset
    #12;
    chk("rst rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst rsp_status", int'(bus.rsp_status), 0);
    chk("rst rsp_balance", int'(bus.rsp_balance), 0);
    chk("rst mem_we", int'(bus.mem_we), 0);
    chk("rst mem_addr", int'(bus.mem_addr), 0);
    chk("rst mem_wdata", int'(bus.mem_wdata), 0);
`ifdef ATM_TXN_COUNT_EN
    chk("rst txn_count", int'(txn_count), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst req_ready", int'(bus.req_ready), 1);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-pressure: response held 5 cycles, a second request waits for the handshake.
    bus.rsp_ready  = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_id     = 4'd3;
    bus.req_op     = 2'b00;
    bus.req_amount = 5'd0;
    push_exp(2'b00, 5'd7);
    @(posedge clk);
    #1;
    bus.req_op     = 2'b01;
    bus.req_amount = 5'd1;
    wait_rsp(lat);
    chk("bp latency", lat, 3);
    for (int c = 0; c < 5; c++) begin
      chk("bp rsp_valid", int'(bus.rsp_valid), 1);
      chk("bp rsp_status", int'(bus.rsp_status), 0);
      chk("bp rsp_balance", int'(bus.rsp_balance), 7);
      chk("bp req_ready", int'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    check_resp("bp first");
    @(posedge clk);
    @(negedge clk);
    chk("bp idle req_ready", int'(bus.req_ready), 1);
    push_exp(2'b00, 5'd8);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp second latency", lat, 4);
    check_resp("bp second");
    @(posedge clk);
    @(negedge clk);
    chk("bp ram3", int'(ram[3]), 8);
`ifdef ATM_TXN_COUNT_EN
    chk("txn_count", int'(txn_count), ok_cnt);
`endif

    // Reset asserted while the write is in progress.
    bus.req_valid  = 1'b1;
    bus.req_id     = 4'd3;
    bus.req_op     = 2'b01;
    bus.req_amount = 5'd2;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.mem_we && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("wr mem_we seen", int'(bus.mem_we), 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("wr_rst mem_we", int'(bus.mem_we), 0);
    chk("wr_rst rsp_valid", int'(bus.rsp_valid), 0);
    chk("wr_rst req_ready", int'(bus.req_ready), 1);
    chk("wr_rst rsp_status", int'(bus.rsp_status), 0);
    chk("wr_rst rsp_balance", int'(bus.rsp_balance), 0);
    chk("wr_rst mem_addr", int'(bus.mem_addr), 0);
    chk("wr_rst mem_wdata", int'(bus.mem_wdata), 0);
`ifdef ATM_TXN_COUNT_EN
    chk("wr_rst txn_count", int'(txn_count), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel req_ready", int'(bus.req_ready), 1);
    chk("rel rsp_valid", int'(bus.rsp_valid), 0);

    // Controller is usable again after the reset.
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_id     = 4'd5;
    bus.req_op     = 2'b00;
    bus.req_amount = 5'd0;
    push_exp(2'b00, 5'd31);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(lat);
    chk("final latency", lat, 3);
    check_resp("final");
    @(posedge clk);
    @(negedge clk);
    chk("final writes", int'(wr_cnt - wr0), 0);
    chk("final sb empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
